regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised integer register file with an integrated per-register scoreboard and a sequential bulk-clear engine. It sits in the decode stage: it supplies two source operands plus their pending (in-flight producer) flags, takes one writeback port, and takes one allocation port from issue. Register 0 is hard-wired to zero and is never pending.

## Interface
- XLEN, 32, data width of each register.
- AW, 5, address width; DEPTH = 2**AW registers.

- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_rs1_addr  in  AW  read port 1 address.
- i_rs2_addr  in  AW  read port 2 address.
- o_rs1_data  out  XLEN  read port 1 data (combinational).
- o_rs2_data  out  XLEN  read port 2 data (combinational).
- o_rs1_pend  out  1  register rs1 has an outstanding producer.
- o_rs2_pend  out  1  register rs2 has an outstanding producer.
- i_rd_addr  in  AW  writeback address.
- i_rd_data  in  XLEN  writeback data.
- i_rd_wen  in  1  writeback enable.
- i_alloc_addr  in  AW  destination being issued.
- i_alloc_en  in  1  set pending bit of i_alloc_addr.
- i_clear  in  1  one-cycle request to zero all registers and pending bits.
- o_clear_busy  out  1  clear engine active.

## Operation
- State: regs[DEPTH] of XLEN bits, pend[DEPTH] bits, clear FSM {IDLE, CLEAR}, counter clr_idx (AW bits).
- Reset (i_rst_n=0, asynchronous): all regs = 0, all pend = 0, FSM = IDLE, clr_idx = 0, o_clear_busy = 0; read outputs therefore 0.
- Read: address 0 -> data 0, pend 0; otherwise regs[addr], pend[addr].
- Writeback (IDLE, i_rd_wen=1, i_rd_addr≠0): regs[i_rd_addr] <= i_rd_data; pend[i_rd_addr] <= 0.
- Allocate (IDLE, i_alloc_en=1, i_alloc_addr≠0): pend[i_alloc_addr] <= 1.
- Same address writeback and allocate in one cycle: data written, pend ends 1 (new producer wins).
- Address 0: writes and allocates are ignored.
- IDLE + i_clear=1: -> CLEAR, clr_idx <= 1; writeback/allocate in that cycle dropped.
- CLEAR: each cycle regs[clr_idx] <= 0, pend[clr_idx] <= 0, clr_idx++; at clr_idx = DEPTH-1, after clearing it, -> IDLE.
- In CLEAR: o_clear_busy = 1; all read data and pend outputs forced 0; i_rd_wen, i_alloc_en, i_clear ignored (caller stalls).
- clr_idx wraps naturally to 0 on exit; no other wrap case exists.

## Timing
- Read latency: 0 cycles (combinational from address and state).
- Write/allocate visible on read ports the cycle after the edge (unless bypass compiled in).
- Clear: o_clear_busy rises the cycle after i_clear is sampled and stays high exactly DEPTH-1 cycles (31 at defaults); first normal access allowed the cycle o_clear_busy is low.
- Reset asserted mid-clear: FSM returns to IDLE immediately; all state zero.

## Configuration
- REGFILE_BYPASS_EN defined: in IDLE, if i_rd_wen=1, i_rd_addr≠0 and i_rd_addr equals a read address, that port returns i_rd_data and its pend output is 0 in the same cycle.
- Not defined: no bypass; reads return pre-edge contents and pend.

## Test plan
- Reset: assert i_rst_n=0 mid-cycle -> all reads 0, pend 0, o_clear_busy 0 without a clock edge.
- Write x5=0xDEADBEEF, read rs1=5 next cycle -> 0xDEADBEEF; write x0=0x1234 -> read x0 = 0.
- Alloc x7, read rs2=7 -> pend 1; writeback x7=0x55 -> next cycle pend 0, data 0x55; alloc+write x7 same cycle -> pend 1, data updated.
- Bypass: write x3=0xA5A5A5A5 with rs1=3 same cycle -> with REGFILE_BYPASS_EN data 0xA5A5A5A5 pend 0; without, old value.
- Fill x1..x31 with index, pulse i_clear -> o_clear_busy high 31 cycles, writes during it ignored, afterwards all reads 0.
- Reset during CLEAR at clr_idx=10 -> o_clear_busy 0 immediately, all registers 0.

Source files
------------

// File: rtl/regfile_sb_if.sv
// ---------------------------------------------------------------------------
// regfile_sb_if
//   Bus bundle between decode/issue logic (master) and the register file
//   with scoreboard (slave).
//
//   Signals (directions seen from the register file):
//     i_rs1_addr, i_rs2_addr   read port addresses
//     o_rs1_data, o_rs2_data   read port data (combinational)
//     o_rs1_pend, o_rs2_pend   outstanding-producer flags for the read ports
//     i_rd_addr, i_rd_data,
//     i_rd_wen                 writeback port
//     i_alloc_addr, i_alloc_en allocation port from issue
//     i_clear                  one-cycle bulk-clear request
//     o_clear_busy             clear engine active
// ---------------------------------------------------------------------------
interface regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic [AW-1:0]   i_rs1_addr;
    logic [AW-1:0]   i_rs2_addr;
    logic [XLEN-1:0] o_rs1_data;
    logic [XLEN-1:0] o_rs2_data;
    logic            o_rs1_pend;
    logic            o_rs2_pend;
    logic [AW-1:0]   i_rd_addr;
    logic [XLEN-1:0] i_rd_data;
    logic            i_rd_wen;
    logic [AW-1:0]   i_alloc_addr;
    logic            i_alloc_en;
    logic            i_clear;
    logic            o_clear_busy;

    modport master (
        output i_rs1_addr, i_rs2_addr,
        output i_rd_addr, i_rd_data, i_rd_wen,
        output i_alloc_addr, i_alloc_en,
        output i_clear,
        input  o_rs1_data, o_rs2_data, o_rs1_pend, o_rs2_pend,
        input  o_clear_busy
    );

    modport slave (
        input  i_rs1_addr, i_rs2_addr,
        input  i_rd_addr, i_rd_data, i_rd_wen,
        input  i_alloc_addr, i_alloc_en,
        input  i_clear,
        output o_rs1_data, o_rs2_data, o_rs1_pend, o_rs2_pend,
        output o_clear_busy
    );
endinterface

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
//   Integer register file with a per-register scoreboard (pending bits) and
//   a sequential bulk-clear engine. Register 0 always reads zero and is
//   never pending.
//
//   Ports:
//     i_clk    clock, all state updates on the rising edge
//     i_rst_n  asynchronous active-low reset (regs, pend, FSM all cleared)
//     bus      regfile_sb_if.slave: two read ports with pending flags,
//              writeback port, allocation port, clear request / busy
//
//   Parameters: XLEN data width, AW address width (2**AW registers).
//
//   Build option: define REGFILE_BYPASS_EN to forward a same-cycle
//   writeback onto a matching read port. Without it, reads always return
//   the contents held before the next clock edge.
// ---------------------------------------------------------------------------
module regfile_sb #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    regfile_sb_if.slave bus
);
    localparam int            DEPTH     = 2 ** AW;
    localparam logic [AW-1:0] ZERO_ADDR = '0;
    localparam logic [AW-1:0] LAST_IDX  = {AW{1'b1}};

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t          state;
    logic [AW-1:0]   clr_idx;
    logic            clear_busy;
    logic [XLEN-1:0] regs [DEPTH];
    logic [DEPTH-1:0] pend;

    logic            is_idle;
    logic            wr_fire;
    logic            alloc_fire;

    // A clear request takes priority: writeback and allocate sampled in the
    // same cycle are dropped, since the clear would wipe them anyway.
    always_comb begin
        is_idle    = (state == IDLE);
        wr_fire    = is_idle && !bus.i_clear && bus.i_rd_wen
                     && (bus.i_rd_addr != ZERO_ADDR);
        alloc_fire = is_idle && !bus.i_clear && bus.i_alloc_en
                     && (bus.i_alloc_addr != ZERO_ADDR);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            clr_idx    <= '0;
            clear_busy <= 1'b0;
            pend       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (state == IDLE) begin
                if (bus.i_clear) begin
                    // Register 0 is never written, so the sweep starts at 1.
                    state      <= CLEAR;
                    clr_idx    <= AW'(1);
                    clear_busy <= 1'b1;
                end
            end else begin
                regs[clr_idx] <= '0;
                pend[clr_idx] <= 1'b0;
                clr_idx       <= clr_idx + AW'(1);
                if (clr_idx == LAST_IDX) begin
                    state      <= IDLE;
                    clear_busy <= 1'b0;
                end
            end

            if (wr_fire) begin
                regs[bus.i_rd_addr] <= bus.i_rd_data;
                pend[bus.i_rd_addr] <= 1'b0;
            end
            // Ordered after the writeback so a new producer on the same
            // register leaves it pending.
            if (alloc_fire) begin
                pend[bus.i_alloc_addr] <= 1'b1;
            end
        end
    end

    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            rs1_pend;
    logic            rs2_pend;

    // Reads are forced to zero while the clear sweep runs so that callers
    // never observe a half-cleared file.
    always_comb begin
        rs1_data = '0;
        rs1_pend = 1'b0;
        rs2_data = '0;
        rs2_pend = 1'b0;
        if (is_idle) begin
            if (bus.i_rs1_addr != ZERO_ADDR) begin
                rs1_data = regs[bus.i_rs1_addr];
                rs1_pend = pend[bus.i_rs1_addr];
            end
            if (bus.i_rs2_addr != ZERO_ADDR) begin
                rs2_data = regs[bus.i_rs2_addr];
                rs2_pend = pend[bus.i_rs2_addr];
            end
`ifdef REGFILE_BYPASS_EN
            if (bus.i_rd_wen && (bus.i_rd_addr != ZERO_ADDR)
                && (bus.i_rd_addr == bus.i_rs1_addr)) begin
                rs1_data = bus.i_rd_data;
                rs1_pend = 1'b0;
            end
            if (bus.i_rd_wen && (bus.i_rd_addr != ZERO_ADDR)
                && (bus.i_rd_addr == bus.i_rs2_addr)) begin
                rs2_data = bus.i_rd_data;
                rs2_pend = 1'b0;
            end
`endif
        end
    end

    assign bus.o_rs1_data   = rs1_data;
    assign bus.o_rs1_pend   = rs1_pend;
    assign bus.o_rs2_data   = rs2_data;
    assign bus.o_rs2_pend   = rs2_pend;
    assign bus.o_clear_busy = clear_busy;

endmodule

// File: tb/tb_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_sb
//   Self-checking bench for regfile_sb: directed vector table, random
//   traffic against a behavioural model, and hand-written sequences for
//   bulk clear and asynchronous reset (including reset during a clear).
// ---------------------------------------------------------------------------
module tb_regfile_sb;
    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b1;

    regfile_sb_if #(.XLEN(XLEN), .AW(AW)) bus ();

    regfile_sb #(.XLEN(XLEN), .AW(AW)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus.slave)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: a clear zeroes the whole file at once and then just
    // counts down the busy window (reads are masked during it anyway).
    logic [31:0] m_regs [DEPTH];
    bit          m_pend [DEPTH];
    int          m_busy_left;

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic        wen;
        logic [4:0]  aa;
        logic        aen;
        logic [31:0] e1;
        logic        ep1;
        logic [31:0] e2;
        logic        ep2;
    } vec_t;

    vec_t vt [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
        m_busy_left = 0;
    endfunction

    function automatic logic [31:0] m_data(input logic [4:0] a);
        if (m_busy_left > 0 || a == 0) return '0;
        if (BYP && bus.i_rd_wen && bus.i_rd_addr != 0 && bus.i_rd_addr == a) return bus.i_rd_data;
        return m_regs[a];
    endfunction

    function automatic logic m_pnd(input logic [4:0] a);
        if (m_busy_left > 0 || a == 0) return 1'b0;
        if (BYP && bus.i_rd_wen && bus.i_rd_addr != 0 && bus.i_rd_addr == a) return 1'b0;
        return m_pend[a];
    endfunction

    function automatic void model_update();
        if (m_busy_left > 0) begin
            m_busy_left--;
        end else if (bus.i_clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_regs[i] = '0;
                m_pend[i] = 1'b0;
            end
            m_busy_left = DEPTH - 1;
        end else begin
            if (bus.i_rd_wen && bus.i_rd_addr != 0) begin
                m_regs[bus.i_rd_addr] = bus.i_rd_data;
                m_pend[bus.i_rd_addr] = 1'b0;
            end
            if (bus.i_alloc_en && bus.i_alloc_addr != 0) m_pend[bus.i_alloc_addr] = 1'b1;
        end
    endfunction

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [31:0] wdata, input logic wen,
                          input logic [4:0] aa, input logic aen, input logic clr);
        bus.i_rs1_addr   = rs1;
        bus.i_rs2_addr   = rs2;
        bus.i_rd_addr    = rd;
        bus.i_rd_data    = wdata;
        bus.i_rd_wen     = wen;
        bus.i_alloc_addr = aa;
        bus.i_alloc_en   = aen;
        bus.i_clear      = clr;
    endtask

    task automatic check_outputs(input string name);
        chk({name, " rs1_data"}, bus.o_rs1_data, m_data(bus.i_rs1_addr));
        chk({name, " rs1_pend"}, 32'(bus.o_rs1_pend), 32'(m_pnd(bus.i_rs1_addr)));
        chk({name, " rs2_data"}, bus.o_rs2_data, m_data(bus.i_rs2_addr));
        chk({name, " rs2_pend"}, 32'(bus.o_rs2_pend), 32'(m_pnd(bus.i_rs2_addr)));
        chk({name, " busy"}, 32'(bus.o_clear_busy), 32'(m_busy_left > 0));
    endtask

    // Called at a falling edge; leaves the caller at the next falling edge.
    task automatic tick();
        @(posedge i_clk);
        model_update();
        @(negedge i_clk);
    endtask

    task automatic step(input string name);
        #1;
        check_outputs(name);
        tick();
    endtask

    task automatic fill_all(input logic with_alloc);
        for (int i = 1; i < DEPTH; i++) begin
            set_in(5'(i - 1), 5'(i), 5'(i), 32'(i), 1'b1, 5'(i), with_alloc, 1'b0);
            step($sformatf("fill x%0d", i));
        end
        set_in(5'd0, 5'd0, 5'd0, '0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // Assert reset between edges and check every address reads zero
    // while it is held; no clock edge is needed for the outputs to clear.
    task automatic reset_sweep(input string name);
        set_in(5'd0, 5'd0, 5'd0, '0, 1'b0, 5'd0, 1'b0, 1'b0);
        #2;
        i_rst_n = 1'b0;
        model_reset();
        #1;
        chk({name, " busy"}, 32'(bus.o_clear_busy), 32'd0);
        for (int a = 0; a < DEPTH; a++) begin
            bus.i_rs1_addr = 5'(a);
            bus.i_rs2_addr = 5'(DEPTH - 1 - a);
            #1;
            chk($sformatf("%s rs1_data x%0d", name, a), bus.o_rs1_data, 32'd0);
            chk($sformatf("%s rs1_pend x%0d", name, a), 32'(bus.o_rs1_pend), 32'd0);
            chk($sformatf("%s rs2_pend x%0d", name, DEPTH - 1 - a), 32'(bus.o_rs2_pend), 32'd0);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cycles;
        logic [4:0] rd, aa, rs1, rs2;

        set_in(5'd5, 5'd31, 5'd0, '0, 1'b0, 5'd0, 1'b0, 1'b0);
        model_reset();
        #1;
        i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        #1;
        check_outputs("reset");
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Directed vector table.
        vt[0] = '{5'd1, 5'd2, 5'd5, 32'hDEADBEEF, 1'b1, 5'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0};
        vt[1] = '{5'd5, 5'd0, 5'd0, 32'h00001234, 1'b1, 5'd0, 1'b0, 32'hDEADBEEF, 1'b0, 32'd0, 1'b0};
        vt[2] = '{5'd0, 5'd5, 5'd0, 32'd0, 1'b0, 5'd7, 1'b1, 32'd0, 1'b0, 32'hDEADBEEF, 1'b0};
        vt[3] = '{5'd5, 5'd7, 5'd7, 32'h55, 1'b1, 5'd0, 1'b0, 32'hDEADBEEF, 1'b0,
                  BYP ? 32'h55 : 32'd0, !BYP};
        vt[4] = '{5'd7, 5'd7, 5'd7, 32'h66, 1'b1, 5'd7, 1'b1,
                  BYP ? 32'h66 : 32'h55, 1'b0, BYP ? 32'h66 : 32'h55, 1'b0};
        vt[5] = '{5'd7, 5'd5, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'h66, 1'b1, 32'hDEADBEEF, 1'b0};
        vt[6] = '{5'd3, 5'd5, 5'd3, 32'hA5A5A5A5, 1'b1, 5'd0, 1'b0,
                  BYP ? 32'hA5A5A5A5 : 32'd0, 1'b0, 32'hDEADBEEF, 1'b0};
        vt[7] = '{5'd3, 5'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'hA5A5A5A5, 1'b0, 32'd0, 1'b0};
        vt[8] = '{5'd0, 5'd3, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 32'hA5A5A5A5, 1'b0};

        for (int v = 0; v < 9; v++) begin
            set_in(vt[v].rs1, vt[v].rs2, vt[v].rd, vt[v].wdata, vt[v].wen, vt[v].aa, vt[v].aen, 1'b0);
            #1;
            chk($sformatf("vec%0d rs1_data", v), bus.o_rs1_data, vt[v].e1);
            chk($sformatf("vec%0d rs1_pend", v), 32'(bus.o_rs1_pend), 32'(vt[v].ep1));
            chk($sformatf("vec%0d rs2_data", v), bus.o_rs2_data, vt[v].e2);
            chk($sformatf("vec%0d rs2_pend", v), 32'(bus.o_rs2_pend), 32'(vt[v].ep2));
            chk($sformatf("vec%0d busy", v), 32'(bus.o_clear_busy), 32'd0);
            tick();
        end

        // Random traffic, including occasional clears and ignored inputs
        // while the clear engine is busy.
        for (int n = 0; n < 400; n++) begin
            rd  = 5'($urandom_range(0, DEPTH - 1));
            aa  = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, DEPTH - 1));
            rs1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, DEPTH - 1));
            rs2 = ($urandom_range(0, 3) == 0) ? aa : 5'($urandom_range(0, DEPTH - 1));
            set_in(rs1, rs2, rd, $urandom, 1'($urandom_range(0, 1)), aa,
                   1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
            step($sformatf("rand%0d", n));
        end

        // Drain any clear left running by the random phase.
        set_in(5'd0, 5'd0, 5'd0, '0, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int k = 0; k < 40 && m_busy_left > 0; k++) step("drain");

        // Fill, clear, count the busy window while hammering writes.
        fill_all(1'b0);
        set_in(5'd4, 5'd9, 5'd4, 32'hFFFF_FFFF, 1'b1, 5'd4, 1'b1, 1'b1);
        step("clear req");
        busy_cycles = 0;
        for (int k = 0; k < 40; k++) begin
            set_in(5'(k), 5'(k + 1), 5'(k + 1), $urandom, 1'b1, 5'(k + 2), 1'b1, 1'($urandom_range(0, 1)));
            #1;
            if (!bus.o_clear_busy) break;
            busy_cycles++;
            check_outputs("in clear");
            tick();
        end
        chk("clear busy length", 32'(busy_cycles), 32'(DEPTH - 1));
        for (int a = 0; a < DEPTH; a++) begin
            set_in(5'(a), 5'(DEPTH - 1 - a), 5'd0, '0, 1'b0, 5'd0, 1'b0, 1'b0);
            #1;
            chk($sformatf("post clear x%0d", a), bus.o_rs1_data, 32'd0);
            check_outputs("post clear");
            tick();
        end

        // Mid-cycle reset with every register written and pending.
        fill_all(1'b1);
        reset_sweep("reset idle");

        // Reset while the clear engine is at clr_idx = 10.
        fill_all(1'b1);
        set_in(5'd0, 5'd0, 5'd0, '0, 1'b0, 5'd0, 1'b0, 1'b1);
        step("clear req2");
        set_in(5'd12, 5'd20, 5'd0, '0, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) step("clear run");
        reset_sweep("reset in clear");
        for (int a = 1; a < DEPTH; a += 5) begin
            set_in(5'(a), 5'(a + 1), 5'd0, '0, 1'b0, 5'd0, 1'b0, 1'b0);
            step("after reset");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
